m21_rr_arbiter: RTL
===================

// Module: m21_rr_arbiter
//
// PURPOSE
//   Round-robin arbiter and sequencer for the 2:1 multiplexer datapath.
//   Two requesters (I0, I1) compete for one shared output channel Y.
//   The block drives the mux select S0, accepts one data beat per cycle from the granted side
//   and registers it onto a valid/ready output stage.
//   A grant is held for bursts of up to MAX_BURST beats, so neither side can starve the other.
//
// PARAMETERS
//   WIDTH      8   data width of I0_DATA, I1_DATA and Y_DATA
//   MAX_BURST  4   max consecutive beats per grant while the other side waits (>=1)
//
// PORTS
//   CLK        in   1      rising-edge clock
//   RST        in   1      reset, asynchronous, active-high
//   I0_VALID   in   1      requester 0 has a beat; held until accepted
//   I0_DATA    in   WIDTH  requester 0 beat
//   I0_READY   out  1      beat 0 accepted this cycle when I0_VALID & I0_READY
//   I1_VALID   in   1      requester 1 has a beat; held until accepted
//   I1_DATA    in   WIDTH  requester 1 beat
//   I1_READY   out  1      beat 1 accepted this cycle when I1_VALID & I1_READY
//   S0         out  1      mux select, registered: 0 = I0, 1 = I1
//   Y_VALID    out  1      output beat valid, registered
//   Y_DATA     out  WIDTH  output beat, registered
//   Y_READY    in   1      downstream accepts Y when Y_VALID & Y_READY
//
// BEHAVIOUR
//   Reset (async, RST=1):
//     - state=IDLE, S0=0, Y_VALID=0, Y_DATA=0, beat count=0.
//     - last_grant=1, so I0 wins the first tie.
//     - I0_READY=I1_READY=0 while RST=1.
//     - Any in-flight Y beat is dropped.
//   States: IDLE, G0 (S0=0), G1 (S0=1). S0 follows state; S0 holds its last value in IDLE.
//   Output stage:
//     - load = !Y_VALID | Y_READY.
//     - I0_READY = (state==G0) & load; I1_READY = (state==G1) & load.
//     - On a transfer: Y_DATA <= selected data, Y_VALID <= 1.
//     - On load without a transfer: Y_VALID <= 0.
//     - Y_READY=0 while Y_VALID=1: Y_DATA/Y_VALID held stable, READYs 0, count held.
//   IDLE transitions:
//     - only I0_VALID -> G0; only I1_VALID -> G1.
//     - both -> side != last_grant; none -> stay IDLE.
//     - Entering Gx: last_grant <= x, count <= 0.
//   Gx transitions (evaluated each cycle):
//     - Ix_VALID=0 -> go to G(other) if other VALID, else IDLE; count <= 0. Costs one bubble cycle.
//     - Transfer with count==MAX_BURST-1:
//       - other VALID -> switch directly to G(other), count <= 0, no bubble.
//       - other idle -> stay in Gx, count <= 0.
//     - Transfer otherwise -> count+1. No transfer -> hold.
//   Count width: clog2(MAX_BURST), minimum 1 bit. MAX_BURST=1 alternates every beat under contention.
//   Latency:
//     - Ix_VALID rise in IDLE (cycle n) -> grant state at n+1 -> first Y_VALID at n+2.
//     - Continuous streaming: 1 beat/cycle, including across burst switches.
//   Ordering: beats from one requester appear on Y in acceptance order; no loss, no duplication.
//   Simultaneous events:
//     - A switch and the last-beat transfer in the same cycle both occur.
//     - A VALID drop on the ungranted side has no effect.
//
// TESTING
//   1 Reset: assert RST mid-burst (async, between edges)
//       -> Y_VALID=0, S0=0, I0_READY=I1_READY=0 immediately.
//       After release, a tie grants I0 first.
//   2 Single stream: I0 sends 0x11,0x22,0x33 back-to-back, Y_READY=1
//       -> Y_DATA 0x11,0x22,0x33 on consecutive cycles.
//       First Y_VALID 2 cycles after I0_VALID; S0=0 throughout.
//   3 Contention, MAX_BURST=4: both sides stream continuously
//       -> Y carries 4 I0 beats, then 4 I1 beats, repeating.
//       S0 toggles every 4 transfers; no idle Y cycle at switches.
//   4 Tie after reset: I0_VALID, I1_VALID rise on the same edge
//       -> G0 first; I1 granted after 4 I0 beats.
//   5 Backpressure: Y_READY=0 for 3 cycles mid-burst
//       -> Y_DATA stable, both READY=0, count frozen.
//       Resume gives the exact remaining sequence, no dup/drop.
//   6 Early release: I0 sends 2 beats then drops VALID while I1 waits
//       -> one bubble cycle, then S0=1 and I1 beats follow.
//       The next tie favours I0.

Source files
------------

// File: rtl/m21_rr_arbiter.sv
// Round-robin arbiter for two valid/ready requesters sharing one
// registered output channel. Bursts are capped at MAX_BURST beats.
module m21_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I0_VALID,
  input  logic [WIDTH-1:0] I0_DATA,
  output logic             I0_READY,
  input  logic             I1_VALID,
  input  logic [WIDTH-1:0] I1_DATA,
  output logic             I1_READY,
  output logic             S0,
  output logic             Y_VALID,
  output logic [WIDTH-1:0] Y_DATA,
  input  logic             Y_READY
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CLAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } st_t;

  st_t             state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s0_q, s0_d;
  logic            yv_q, yv_d;
  logic [WIDTH-1:0] yd_q, yd_d;

  logic load;
  logic rdy0, rdy1;
  logic xfer0, xfer1;

  assign load  = !yv_q | Y_READY;
  assign xfer0 = rdy0 & I0_VALID;
  assign xfer1 = rdy1 & I1_VALID;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      s0_q    <= 1'b0;
      yv_q    <= 1'b0;
      yd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      yv_q    <= yv_d;
      yd_q    <= yd_d;
    end
  end

  // Grant/burst sequencing; a switch on the last beat costs no bubble.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (I0_VALID && (!I1_VALID || last_q)) begin
          state_d = G0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (I1_VALID) begin
          state_d = G1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      G0: begin
        if (!I0_VALID) begin
          cnt_d = '0;
          if (I1_VALID) begin
            state_d = G1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer0) begin
          if (cnt_q == CLAST) begin
            cnt_d = '0;
            if (I1_VALID) begin
              state_d = G1;
              last_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      G1: begin
        if (!I1_VALID) begin
          cnt_d = '0;
          if (I0_VALID) begin
            state_d = G0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer1) begin
          if (cnt_q == CLAST) begin
            cnt_d = '0;
            if (I0_VALID) begin
              state_d = G0;
              last_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rdy0 = (state_q == G0) & load;
    rdy1 = (state_q == G1) & load;
    s0_d = s0_q;
    if (state_d == G1) begin
      s0_d = 1'b1;
    end else if (state_d == G0) begin
      s0_d = 1'b0;
    end
    yv_d = yv_q;
    yd_d = yd_q;
    if (load) begin
      yv_d = xfer0 | xfer1;
      if (xfer0) begin
        yd_d = I0_DATA;
      end else if (xfer1) begin
        yd_d = I1_DATA;
      end
    end
  end

  assign I0_READY = rdy0;
  assign I1_READY = rdy1;
  assign S0       = s0_q;
  assign Y_VALID  = yv_q;
  assign Y_DATA   = yd_q;

endmodule
